ksa_wb_ctrl: RTL

Wishbone-slave front end for the 16-bit Kogge-Stone adder in the user project. Firmware on the management SoC writes two 16-bit operands and a start bit. The block launches them into the combinational adder, waits a fixed settle time, and captures `{cout, sum}` into a 4-entry result FIFO that firmware pops over the bus. An IRQ is raised while results are pending. It sits directly upstream of the adder (it drives `a`/`b`) and downstream of it (it consumes `sum`/`cout`).

---
 rtl/ksa_wb_ctrl_if.sv | 22 ++
 rtl/ksa_wb_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ksa_wb_ctrl_if.sv
// Wishbone slave bus bundle for the Kogge-Stone adder front end.
// Pure wiring; timing and backpressure are set by the attached slave.
interface ksa_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ksa_wb_ctrl.sv
// Wishbone front end for the 16-bit adder: launches operands, captures {cout,sum} into a 4-deep FIFO.
// Ack one cycle after accept (one request per 2 cycles); push SETTLE_CYCLES+1 edges after start; full FIFO drops and flags ovf.
module ksa_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  ksa_wb_ctrl_if.slave  bus,
  output logic [15:0]   a_o,
  output logic [15:0]   b_o,
  input  logic [15:0]   sum_i,
  input  logic          cout_i,
  output logic          irq_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        launch, push;

  logic        ack_q;
  logic [31:0] dat_q;
  logic [15:0] opa_q, opb_q;
  logic        irq_en_q, ovf_q;

  logic [16:0] mem [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;

  logic        adr_match, accept, wr, rd;
  logic [1:0]  reg_sel;
  logic        start_req, ctrl_wr;
  logic        empty, full, pop, do_push, ovf_set;
  logic [31:0] status, rdata;
  logic        unused_ok;

  assign adr_match = (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept    = bus.wbs_stb_i & bus.wbs_cyc_i & adr_match & ~ack_q;
  assign wr        = accept & bus.wbs_we_i;
  assign rd        = accept & ~bus.wbs_we_i;
  assign reg_sel   = bus.wbs_adr_i[3:2];
  assign ctrl_wr   = wr && (reg_sel == 2'd0);
  assign start_req = ctrl_wr && bus.wbs_dat_i[0];

  assign unused_ok = &{1'b0, bus.wbs_sel_i, bus.wbs_adr_i[1:0], bus.wbs_dat_i[31:16]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
          launch  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == 3'd0);
  assign full    = (count_q == 3'd4);
  assign pop     = rd && (reg_sel == 2'd3) && !empty;
  // A pop on the capture edge frees the slot the new result needs.
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  assign status = {23'd0, irq_en_q, 1'b0, count_q, ovf_q, full, empty, (state_q != IDLE)};

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      2'd0: rdata = status;
      2'd1: rdata = {16'd0, opa_q};
      2'd2: rdata = {16'd0, opb_q};
      2'd3: rdata = empty ? 32'd0 : {15'd0, mem[rd_ptr_q]};
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      opa_q    <= 16'd0;
      opb_q    <= 16'd0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      a_o      <= 16'd0;
      b_o      <= 16'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= accept;
      dat_q   <= rd ? rdata : 32'd0;
      if (ctrl_wr) irq_en_q <= bus.wbs_dat_i[8];
      if (wr && reg_sel == 2'd1) opa_q <= bus.wbs_dat_i[15:0];
      if (wr && reg_sel == 2'd2) opb_q <= bus.wbs_dat_i[15:0];
      if (launch) begin
        a_o <= opa_q;
        b_o <= opb_q;
      end
      if (ovf_set)                           ovf_q <= 1'b1;
      else if (ctrl_wr && bus.wbs_dat_i[3])  ovf_q <= 1'b0;
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + 3'(do_push) - 3'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr_q] <= {cout_i, sum_i};
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign irq_o         = irq_en_q & ~empty;

endmodule
